aes_key_expander: RTL
=====================

Name: aes_key_expander

Overview:
- Sequential AES key schedule supporting 128-, 192- and 256-bit keys, selected per run on `key_size`.
- Generates one 32-bit schedule word per clock into an internal round-key store.
- Exposes any round key through a registered read port.
- Successor to the fixed AES-128 combinational key block; feeds the iterative cipher/decipher round datapath.

Parameters:
- MAX_NK, 8, largest key length in 32-bit words supported (4, 6 or 8); sizes the store as 4*(MAX_NK+7) words and restricts legal `key_size`.
- RK_RESET_ZERO, 1, when 1 the store is not cleared but `rk_out` reads zero until `key_valid`; when 0 `rk_out` shows raw store contents.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous active-high reset
- start  in  1  one-cycle request to expand `key_in`; sampled only in IDLE
- key_size  in  2  0=AES-128 (Nk=4, Nr=10), 1=AES-192 (Nk=6, Nr=12), 2=AES-256 (Nk=8, Nr=14), 3=illegal
- key_in  in  256  cipher key, MSB-aligned: AES-128 uses [255:128], AES-192 uses [255:64]; unused LSBs ignored
- busy  out  1  high while expansion in progress
- done  out  1  one-cycle pulse when the last word is written
- key_valid  out  1  high from `done` until next accepted start or RST
- err  out  1  one-cycle pulse when start is accepted with illegal `key_size` or Nk>MAX_NK
- rk_idx  in  4  round key index 0..Nr
- rk_out  out  128  round key rk_idx = w[4r]..w[4r+3], w[4r] in [127:96]; registered, 1-cycle latency

Behaviour:
- Reset: busy=0, done=0, key_valid=0, err=0, rk_out=0, FSM=IDLE, word counter i=0. RST mid-expansion aborts immediately to IDLE; no `done`.
- Reset priority: RST overrides start in the same cycle.
- FSM states and transitions:
  - IDLE: on start with legal size, latch Nk/Nr, write w[0..Nk-1] from `key_in` in that edge, set i=Nk, busy=1, key_valid=0, go GEN.
  - IDLE, illegal size on start: pulse err, stay IDLE, key_valid unchanged.
  - GEN: each cycle compute w[i] and write it to the store, then i++.
    - temp=w[i-1]
    - if i mod Nk==0: temp=SubWord(RotWord(temp))^Rcon[i/Nk]
    - else if Nk==8 and i mod Nk==4: temp=SubWord(temp)
    - w[i]=w[i-Nk]^temp
    - Rcon sequence 01,02,04,08,10,20,40,80,1b,36, placed in the MSB byte.
    - After writing w[4*Nr+3], go DONE.
  - DONE: one cycle; done=1, busy=0, key_valid=1; next state IDLE.
- Track i mod Nk with a wrapping sub-counter, not a divider.
- Latency: GEN cycles N = 4(Nr+1)-Nk = 40 / 46 / 52. `done` is first seen high N+1 edges after the edge that accepted start.
- start while busy or in DONE is ignored, with no error.
- key_in and key_size are sampled only at the accepting edge; later changes have no effect on the run.
- SubWord uses 4 internal combinational S-box instances; no external dependency.
- Read port: rk_out <= store[4*rk_idx..4*rk_idx+3] every cycle.
  - rk_idx>Nr: rk_out=0.
  - key_valid=0 and RK_RESET_ZERO=1: rk_out=0.
  - Reads during GEN are permitted; contents are valid only after key_valid.

Test Plan:
- AES-128 (FIPS-197 C.1): key_in[255:128]=000102030405060708090a0b0c0d0e0f, key_size=0, start.
  - done 41 edges later.
  - rk_idx=0 gives 000102030405060708090a0b0c0d0e0f.
  - rk_idx=10 gives 13111d7fe3944a17f307a78b4d2b30c5.
  - rk_idx=11 gives 0.
- AES-128 (App. A): key 2b7e151628aed2a6abf7158809cf4f3c.
  - rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Then a second run with key 00102030405060708090a0b0c0d0e0f0: key_valid drops at start and K0 matches the new key.
- AES-192: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, key_size=1.
  - done 47 edges after start.
  - rk_idx=12 gives e98ba06f448c773c8ecc720401002202.
- AES-256: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, key_size=2.
  - done 53 edges after start.
  - rk_idx=14 gives fe4890d1e6188d0b046df344706c631e.
- Control (AES-128 run):
  - start pulsed again at cycle 10 of the run: ignored, same result and timing.
  - RST asserted at cycle 20: busy=0, no done, key_valid=0, rk_out=0.
- Illegal size: key_size=3, start -> err pulse one cycle, busy stays 0. With MAX_NK=4, key_size=2 -> err.

Source files
------------

// File: rtl/aes_key_expander.sv
// AES key schedule for 128/192/256-bit keys: one schedule word per clock into
// an internal round-key store, with a registered 128-bit round-key read port.

// Combinational AES forward S-box
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[a];
endmodule

module aes_key_expander #(
  parameter int unsigned MAX_NK        = 8,
  parameter bit          RK_RESET_ZERO = 1'b1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [1:0]   key_size,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  output logic         err,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);
  localparam int unsigned WORDS = 4 * (MAX_NK + 7);
  localparam int unsigned IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      store [WORDS];
  logic [IDX_W-1:0] i_q, last_q, rd_base;
  logic [3:0]       nk_q, nr_q, mod_q, nk_sel, nr_sel;
  logic [7:0]       rcon_q;
  logic             size_ok, accept, reject;
  logic             busy_d, done_d, key_valid_d, err_d;
  logic [31:0]      prev_w, back_w, sub_in, sub_out, temp_w, new_w;

  // Decode key_size into Nk/Nr and legality against MAX_NK
  always_comb begin
    nk_sel = 4'd4;
    nr_sel = 4'd10;
    case (key_size)
      2'd1:    begin nk_sel = 4'd6; nr_sel = 4'd12; end
      2'd2:    begin nk_sel = 4'd8; nr_sel = 4'd14; end
      default: ;
    endcase
    size_ok = (key_size != 2'd3) && (32'(nk_sel) <= MAX_NK);
  end

  assign accept = (state_q == S_IDLE) && start && size_ok;
  assign reject = (state_q == S_IDLE) && start && !size_ok;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_GEN;
      S_GEN:   if (i_q == last_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic (next values of the registered status outputs)
  always_comb begin
    busy_d      = busy;
    done_d      = 1'b0;
    key_valid_d = key_valid;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          busy_d      = 1'b1;
          key_valid_d = 1'b0;
        end
        if (reject) err_d = 1'b1;
      end
      S_GEN:  busy_d = 1'b1;
      S_DONE: begin
        busy_d      = 1'b0;
        done_d      = 1'b1;
        key_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Status output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      key_valid <= key_valid_d;
      err       <= err_d;
    end
  end

  // Schedule word recurrence; mod_q tracks i mod Nk
  always_comb begin
    prev_w = store[IDX_W'(i_q - IDX_W'(1))];
    back_w = store[IDX_W'(i_q - IDX_W'(nk_q))];
    sub_in = (mod_q == 4'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    if (mod_q == 4'd0)                        temp_w = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && mod_q == 4'd4)   temp_w = sub_out;
    else                                      temp_w = prev_w;
    new_w = back_w ^ temp_w;
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
  end

  // Counters, latched key geometry and round constant
  always_ff @(posedge CLK) begin
    if (RST) begin
      i_q    <= '0;
      mod_q  <= 4'd0;
      nk_q   <= 4'd4;
      nr_q   <= 4'd10;
      last_q <= IDX_W'(43);
      rcon_q <= 8'h01;
    end else if (accept) begin
      i_q    <= IDX_W'(nk_sel);
      mod_q  <= 4'd0;
      nk_q   <= nk_sel;
      nr_q   <= nr_sel;
      last_q <= IDX_W'({nr_sel, 2'b11});
      rcon_q <= 8'h01;
    end else if (state_q == S_GEN) begin
      i_q   <= i_q + IDX_W'(1);
      mod_q <= (mod_q == nk_q - 4'd1) ? 4'd0 : mod_q + 4'd1;
      if (mod_q == 4'd0)
        rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end
  end

  // Round-key store: key words on accept, one schedule word per GEN cycle
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (accept) begin
        for (int unsigned j = 0; j < MAX_NK; j++)
          if (j < 32'(nk_sel)) store[IDX_W'(j)] <= key_in[255 - 32*j -: 32];
      end else if (state_q == S_GEN) begin
        store[i_q] <= new_w;
      end
    end
  end

  assign rd_base = IDX_W'({rk_idx, 2'b00});

  // Registered round-key read port
  always_ff @(posedge CLK) begin
    if (RST)
      rk_out <= '0;
    else if (rk_idx > nr_q || (RK_RESET_ZERO && !key_valid))
      rk_out <= '0;
    else
      rk_out <= {store[rd_base], store[rd_base + IDX_W'(1)],
                 store[rd_base + IDX_W'(2)], store[rd_base + IDX_W'(3)]};
  end
endmodule
